systolic_array_arbiter: RTL and testbench

Round-robin scheduler that shares one `topSystolicArray` instance between `R` requesters. It accepts one matrix-multiply job at a time over a valid/ready handshake, latches the operands, and issues a single-cycle launch pulse to the array. It then waits for the array's result-valid strobe, latches the result, and returns it to the owning requester over a response handshake.

---
 rtl/systolic_array_arbiter.sv | 149 ++++++++++++++
 tb/tb_systolic_array_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_arbiter.sv
// systolic_array_arbiter: round-robin front end sharing one systolic array
// among R requesters. Define SYSTOLIC_ARB_TIMEOUT_EN to add a BUSY watchdog.
module systolic_array_arbiter #(
  parameter int N       = 4,
  parameter int R       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_arst,
  input  logic [R-1:0]        i_reqValid,
  input  logic [R*N*N*8-1:0]  i_reqA,
  input  logic [R*N*N*8-1:0]  i_reqB,
  output logic [R-1:0]        o_reqReady,
  output logic                o_launch,
  output logic [N*N*8-1:0]    o_a,
  output logic [N*N*8-1:0]    o_b,
  input  logic                i_resultValid,
  input  logic [N*N*32-1:0]   i_c,
  output logic [R-1:0]        o_rspValid,
  output logic [N*N*32-1:0]   o_rspC,
  output logic                o_rspError,
  input  logic                i_rspReady,
  output logic                o_busy
);

  localparam int          PW = $clog2(R);
  localparam int          MW = N*N*8;
  localparam int unsigned RU = R;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LAUNCH  = 2'd1;
  localparam logic [1:0] S_BUSY    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] pick;
  logic          found;
  logic          take;
  logic [MW-1:0] sel_a;
  logic [MW-1:0] sel_b;

`ifdef SYSTOLIC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] wd_cnt;
  logic          rsp_err;
`endif

  function automatic logic [PW-1:0] wrap(input int unsigned v);
    return PW'((v >= RU) ? v - RU : v);
  endfunction

  // First asserted request at or after rr_ptr, wrapping modulo R.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RU; i++) begin
      if (!found && i_reqValid[wrap(32'(rr_ptr) + i)]) begin
        pick  = wrap(32'(rr_ptr) + i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < R; k++) begin
      if (pick == PW'(k)) begin
        sel_a = i_reqA[k*MW +: MW];
        sel_b = i_reqB[k*MW +: MW];
      end
    end
  end

  assign o_reqReady =
    (state == S_IDLE && found && !i_arst) ? R'(1) << pick : '0;
  assign take       = |(i_reqValid & o_reqReady);
  assign o_launch   = (state == S_LAUNCH);
  assign o_busy     = (state != S_IDLE);
  assign o_rspValid =
    (state == S_RESPOND) ? R'(1) << owner : '0;

`ifdef SYSTOLIC_ARB_TIMEOUT_EN
  assign o_rspError = rsp_err;
`else
  assign o_rspError = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      o_a    <= '0;
      o_b    <= '0;
      o_rspC <= '0;
`ifdef SYSTOLIC_ARB_TIMEOUT_EN
      wd_cnt  <= '0;
      rsp_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            o_a   <= sel_a;
            o_b   <= sel_b;
            owner <= pick;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
`ifdef SYSTOLIC_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= S_BUSY;
        end
        S_BUSY: begin
          // A result arriving with an expiring watchdog takes priority.
          if (i_resultValid) begin
            o_rspC <= i_c;
`ifdef SYSTOLIC_ARB_TIMEOUT_EN
            rsp_err <= 1'b0;
`endif
            state  <= S_RESPOND;
          end
`ifdef SYSTOLIC_ARB_TIMEOUT_EN
          else if (wd_cnt == TW'(TIMEOUT)) begin
            o_rspC  <= '0;
            rsp_err <= 1'b1;
            state   <= S_RESPOND;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
`endif
        end
        S_RESPOND: begin
          if (i_rspReady) begin
            rr_ptr <= wrap(32'(owner) + 32'd1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_arbiter.sv
// tb_systolic_array_arbiter: random and directed jobs against a
// transaction-level arbiter model plus a bench-side array model.
module tb_systolic_array_arbiter;

  localparam int N = 4;
  localparam int R = 4;
`ifdef SYSTOLIC_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif
  localparam int MW = N*N*8;
  localparam int CW = N*N*32;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [R-1:0]    req_valid = '0;
  logic [R*MW-1:0] req_a = '0;
  logic [R*MW-1:0] req_b = '0;
  logic [R-1:0]    req_ready;
  logic            launch;
  logic [MW-1:0]   a;
  logic [MW-1:0]   b;
  logic            result_valid = 1'b0;
  logic [CW-1:0]   c_in = '0;
  logic [R-1:0]    rsp_valid;
  logic [CW-1:0]   rsp_c;
  logic            rsp_error;
  logic            rsp_ready = 1'b0;
  logic            busy;

  systolic_array_arbiter #(.N(N), .R(R), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_reqValid(req_valid), .i_reqA(req_a), .i_reqB(req_b),
    .o_reqReady(req_ready), .o_launch(launch), .o_a(a), .o_b(b),
    .i_resultValid(result_valid), .i_c(c_in),
    .o_rspValid(rsp_valid), .o_rspC(rsp_c), .o_rspError(rsp_error),
    .i_rspReady(rsp_ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int launches = 0;
  int grant_q[$];

  bit            m_job = 0, m_res = 0, m_err = 0;
  int            m_owner = 0, m_ptr = 0, m_ths = 0;
  logic [CW-1:0] m_c = '0;
  logic [MW-1:0] m_a = '0, m_b = '0;

  bit            arr_pending = 0, arr_hold = 0;
  int            arr_cnt = 0, arr_lat_max = 3;
  logic [CW-1:0] arr_c = '0;
  logic [R-1:0]  granted = '0;

  task automatic chk(input string name, input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] matmul(input logic [MW-1:0] x,
                                           input logic [MW-1:0] y);
    logic [CW-1:0] r;
    logic [31:0]   s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += 32'(x[(i*N+k)*8 +: 8]) * 32'(y[(k*N+j)*8 +: 8]);
        r[(i*N+j)*32 +: 32] = s;
      end
    return r;
  endfunction

  function automatic int first_from(input logic [R-1:0] v, input int p);
    for (int i = 0; i < R; i++)
      if (v[(p+i)%R]) return (p+i)%R;
    return -1;
  endfunction

  function automatic logic [R-1:0] onehot(input int k);
    logic [R-1:0] r;
    r = '0;
    if (k >= 0) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*8 +: 8] = 8'($urandom_range(255, 0));
    return m;
  endfunction

  // One cycle: check outputs against the model at negedge, advance the
  // model with this cycle's inputs, then step the array model.
  task automatic tick();
    int k;
    @(negedge clk);
    granted = '0;
    if (arst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_launch", launch, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rspv", rsp_valid, 0);
      chk("rst_rspc", rsp_c, 0);
      chk("rst_err", rsp_error, 0);
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      m_job = 0;
      m_ptr = 0;
      arr_pending = 0;
    end else begin
      k = m_job ? -1 : first_from(req_valid, m_ptr);
      chk("ready", req_ready, onehot(k));
      chk("launch", launch, m_job && cyc == m_ths + 1);
      chk("busy", busy, m_job);
      chk("rsp_valid", rsp_valid, (m_job && m_res) ? onehot(m_owner) : '0);
      if (m_job && m_res) begin
        chk("rsp_c", rsp_c, m_c);
        chk("rsp_err", rsp_error, m_err);
      end
`ifndef SYSTOLIC_ARB_TIMEOUT_EN
      chk("err_tied", rsp_error, 0);
`endif
      if (m_job && cyc == m_ths + 1) begin
        chk("a_latch", a, m_a);
        chk("b_latch", b, m_b);
      end
      if (launch) begin
        launches++;
        arr_pending = 1;
        arr_cnt = $urandom_range(arr_lat_max, 0);
        arr_c = matmul(a, b);
      end
      if (k >= 0) begin
        m_job = 1; m_res = 0; m_owner = k; m_ths = cyc;
        m_a = req_a[k*MW +: MW];
        m_b = req_b[k*MW +: MW];
        granted[k] = 1'b1;
        grant_q.push_back(k);
      end else if (m_job && !m_res && cyc >= m_ths + 2) begin
        if (result_valid) begin
          m_res = 1; m_c = c_in; m_err = 0;
        end
`ifdef SYSTOLIC_ARB_TIMEOUT_EN
        else if (cyc - m_ths - 2 == TO) begin
          m_res = 1; m_c = '0; m_err = 1;
        end
`endif
      end else if (m_job && m_res && rsp_ready) begin
        m_job = 0;
        m_ptr = (m_owner + 1) % R;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    req_valid &= ~granted;
    result_valid = 1'b0;
    if (arr_pending && !arr_hold) begin
      if (arr_cnt == 0) begin
        result_valid = 1'b1;
        c_in = arr_c;
        arr_pending = 0;
      end else begin
        arr_cnt--;
      end
    end
  endtask

  task automatic set_job(input int k, input logic [MW-1:0] x,
                         input logic [MW-1:0] y);
    req_a[k*MW +: MW] = x;
    req_b[k*MW +: MW] = y;
    req_valid[k] = 1'b1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    result_valid = 1'b0;
    arr_hold = 0;
    tick();
    tick();
    arst = 1'b0;
    tick();
    launches = 0;
    grant_q.delete();
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (rsp_valid == '0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, |rsp_valid, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    rsp_ready = 1'b1;
    while ((busy || req_valid != '0) && n < 400) begin
      tick();
      n++;
    end
    chk(name, busy || req_valid != '0, 0);
  endtask

  function automatic int owner_of(input logic [R-1:0] v);
    for (int i = 0; i < R; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [MW-1:0] ident, threes, x, y;
    logic [CW-1:0] exp3, g;
    int l0, lc, rc, o, n;

    // Single job from requester 2: identity x all-3 gives all-3.
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_rspv", rsp_valid, 0);
    chk("reset_rspc", rsp_c, 0);
    chk("reset_a", a, 0);
    chk("reset_launch", launch, 0);
    ident = '0;
    threes = '0;
    exp3 = '0;
    for (int i = 0; i < N; i++) ident[(i*N+i)*8 +: 8] = 8'd1;
    for (int i = 0; i < N*N; i++) begin
      threes[i*8 +: 8] = 8'd3;
      exp3[i*32 +: 32] = 32'd3;
    end
    set_job(2, ident, threes);
    wait_rsp("t1_wait");
    chk("t1_rspv", rsp_valid, 4'b0100);
    chk("t1_rspc", rsp_c, exp3);
    chk("t1_launches", launches, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("t1_rrptr", req_ready, 4'b1000);
    drain("t1_drain");

    // All four requesters valid straight out of reset.
    do_reset();
    for (int k = 0; k < R; k++) set_job(k, rnd_mat(), rnd_mat());
    rsp_ready = 1'b1;
    n = 0;
    while ((grant_q.size() < 4 || busy) && n < 300) begin
      tick();
      n++;
      if (rsp_valid != '0) begin
        o = owner_of(rsp_valid);
        chk("t2_gold", rsp_c, matmul(req_a[o*MW +: MW], req_b[o*MW +: MW]));
      end
    end
    chk("t2_count", grant_q.size(), 4);
    if (grant_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("t2_order", grant_q[i], i);

    // Backpressure with others waiting, spurious result in RESPOND.
    rsp_ready = 1'b0;
    x = rnd_mat();
    y = rnd_mat();
    g = matmul(x, y);
    set_job(1, x, y);
    wait_rsp("t3_wait");
    l0 = launches;
    for (int k = 0; k < R; k++) set_job(k, rnd_mat(), rnd_mat());
    grant_q.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_rspv", rsp_valid, 4'b0010);
      chk("t3_rspc", rsp_c, g);
      chk("t3_ready", req_ready, 0);
      if (i == 10) begin
        result_valid = 1'b1;
        c_in = '0;
        c_in[31:0] = $urandom();
      end
    end
    chk("t3_launches", launches, l0);
    drain("t3_drain");
    chk("t3_count", grant_q.size(), 4);
    if (grant_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("t3_order", grant_q[i], (i + 2) % 4);
    result_valid = 1'b1;
    c_in = '1;
    tick();
    tick();
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_rspv", rsp_valid, 0);

    // Reset while BUSY, then a fresh job.
    arr_hold = 1;
    set_job(0, rnd_mat(), rnd_mat());
    for (int i = 0; i < 5; i++) tick();
    chk("t4_busy", busy, 1);
    arst = 1'b1;
    #1;
    chk("t4_launch", launch, 0);
    chk("t4_busy0", busy, 0);
    chk("t4_rspv", rsp_valid, 0);
    chk("t4_a", a, 0);
    chk("t4_b", b, 0);
    chk("t4_rspc", rsp_c, 0);
    tick();
    arst = 1'b0;
    arr_hold = 0;
    tick();
    x = rnd_mat();
    y = rnd_mat();
    set_job(3, x, y);
    rsp_ready = 1'b0;
    wait_rsp("t4_wait");
    chk("t4_new_rspv", rsp_valid, 4'b1000);
    chk("t4_new_rspc", rsp_c, matmul(x, y));
    rsp_ready = 1'b1;
    tick();

`ifdef SYSTOLIC_ARB_TIMEOUT_EN
    // Withheld result: watchdog answers, late result is dropped.
    rsp_ready = 1'b0;
    arr_hold = 1;
    set_job(2, rnd_mat(), rnd_mat());
    lc = -1;
    rc = -1;
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      tick();
      n++;
      if (launch) lc = cyc;
    end
    rc = cyc;
    chk("t5_latency", rc - (lc + 1), 9);
    chk("t5_rspv", rsp_valid, 4'b0100);
    chk("t5_err", rsp_error, 1);
    chk("t5_rspc", rsp_c, 0);
    arr_hold = 0;
    arr_cnt = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_late_err", rsp_error, 1);
    chk("t5_late_rspc", rsp_c, 0);
    rsp_ready = 1'b1;
    tick();
    chk("t5_idle", busy, 0);
`else
    lc = 0;
    rc = 0;
`endif

    // Random traffic.
    do_reset();
    arr_lat_max = 5;
    for (int i = 0; i < 1500; i++) begin
      tick();
      for (int k = 0; k < R; k++)
        if (!req_valid[k] && $urandom_range(3, 0) == 0)
          set_job(k, rnd_mat(), rnd_mat());
      rsp_ready = ($urandom_range(3, 0) != 0);
      if (!busy && !arr_pending && $urandom_range(15, 0) == 0) begin
        result_valid = 1'b1;
        c_in = '0;
        c_in[31:0] = $urandom();
      end
    end
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
